// File: rtl/jtopl_sched_pkg.sv
// Shared types for the slot sequencer: write-FSM state encoding and default ring geometry.
// The counter sub-module is reused by the timer and envelope blocks, so its helpers live here.
package jtopl_sched_pkg;

    localparam int STAGES_DEF = 18;
    localparam int SLOT_LAST  = STAGES_DEF - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } wr_state_t;

    // Prescaler width; DIV=1 still needs a one-bit register that simply never moves.
    function automatic int pre_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/jtopl_slot_cnt.sv
// Prescaler plus slot counter: sh_cen fires on every DIV-th cen, and slot tracks the ring insertion point.
// Zero latency from the registers (sh_cen and zero are pure decodes); cen low freezes everything.
module jtopl_slot_cnt
    import jtopl_sched_pkg::*;
#(
    parameter int STAGES = 18,
    parameter int DIV    = 4,
    parameter int SW     = 5
) (
    input  logic          i_rst,
    input  logic          i_clk,
    input  logic          i_cen,
    output logic          o_sh_cen,
    output logic [SW-1:0] o_slot,
    output logic          o_zero
);

    localparam int            PW       = pre_width(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [SW-1:0] SLOT_END = SW'(STAGES - 1);

    logic [PW-1:0] r_pre;
    logic [SW-1:0] r_slot;
    logic          w_pre_wrap;

    assign w_pre_wrap = (r_pre == PRE_LAST);
    assign o_sh_cen   = i_cen & w_pre_wrap;
    assign o_slot     = r_slot;
    assign o_zero     = (r_slot == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pre <= '0;
        end else if (i_cen) begin
            r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slot <= '0;
        end else if (o_sh_cen) begin
            r_slot <= (r_slot == SLOT_END) ? '0 : r_slot + 1'b1;
        end
    end

endmodule

// File: rtl/jtopl_slot_sched.sv
// Ring sequencer and single-entry write scheduler: one CPU write waits for its slot, then loads the ring once.
// Ack arrives one clk after the loading sh_cen; requests arriving while busy are dropped, not queued.
module jtopl_slot_sched
    import jtopl_sched_pkg::*;
#(
    parameter int STAGES = SLOT_LAST + 1,
    parameter int W      = 8,
    parameter int DIV    = 4,
    parameter int SW     = 5
) (
    input  logic          i_rst,
    input  logic          i_clk,
    input  logic          i_cen,
    output logic          o_sh_cen,
    output logic [SW-1:0] o_slot,
    output logic          o_zero,
    input  logic          i_wr_req,
    input  logic [SW-1:0] i_wr_slot,
    input  logic [W-1:0]  i_wr_din,
    output logic          o_wr_busy,
    output logic          o_wr_ack,
    output logic          o_wr_err,
    output logic          o_sh_load,
    output logic [W-1:0]  o_sh_wdata
);

    // One bit wider than the slot port, since STAGES may equal 2**SW.
    localparam logic [SW:0] STAGES_W = (SW + 1)'(STAGES);

    wr_state_t     r_state;
    logic [SW-1:0] r_target;
    logic [W-1:0]  r_wdata;
    logic          r_err;

    logic          w_sh_cen;
    logic [SW-1:0] w_slot;
    logic          w_zero;
    logic          w_in_range;
    logic          w_hit;

    jtopl_slot_cnt #(
        .STAGES (STAGES),
        .DIV    (DIV),
        .SW     (SW)
    ) u_cnt (
        .i_rst    (i_rst),
        .i_clk    (i_clk),
        .i_cen    (i_cen),
        .o_sh_cen (w_sh_cen),
        .o_slot   (w_slot),
        .o_zero   (w_zero)
    );

    assign w_in_range = ({1'b0, i_wr_slot} < STAGES_W);
    assign w_hit      = (w_slot == r_target);

    // Only IDLE looks at the request, so anything arriving while WAIT/DONE is simply lost.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_wr_req) begin
                        if (w_in_range) begin
                            r_target <= i_wr_slot;
                            r_wdata  <= i_wr_din;
                            r_err    <= 1'b0;
                            r_state  <= ST_WAIT;
                        end else begin
                            r_err    <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_sh_cen && w_hit) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_sh_cen   = w_sh_cen;
    assign o_slot     = w_slot;
    assign o_zero     = w_zero;
    assign o_wr_busy  = (r_state == ST_WAIT);
    assign o_wr_ack   = (r_state == ST_DONE);
    assign o_wr_err   = (r_state == ST_DONE) & r_err;
    // Held for the whole target slot; the ring only shifts on the one sh_cen inside it.
    assign o_sh_load  = (r_state == ST_WAIT) & w_hit;
    assign o_sh_wdata = r_wdata;

endmodule

// File: tb/tb_jtopl_slot_sched.sv
// Directed bench for jtopl_slot_sched with STAGES=18, DIV=4: counter timing, write scheduling and a ring model.
module tb_jtopl_slot_sched;

    localparam int STAGES = 18;
    localparam int W      = 8;
    localparam int DIV    = 4;
    localparam int SW     = 5;

    logic          i_rst, i_clk, i_cen, i_wr_req;
    logic [SW-1:0] i_wr_slot;
    logic [W-1:0]  i_wr_din;
    logic          o_sh_cen, o_zero, o_wr_busy, o_wr_ack, o_wr_err, o_sh_load;
    logic [SW-1:0] o_slot;
    logic [W-1:0]  o_sh_wdata;

    int tests = 0;
    int fails = 0;

    // Reference timing model and the parent's ring contents.
    int           m_pre, m_slot;
    logic         m_shcen;
    logic [W-1:0] ring     [STAGES];
    logic [W-1:0] exp_ring [STAGES];
    int           load_cnt = 0;
    logic [W-1:0] exp_wdata;

    jtopl_slot_sched #(.STAGES(STAGES), .W(W), .DIV(DIV), .SW(SW)) dut (
        .i_rst      (i_rst),
        .i_clk      (i_clk),
        .i_cen      (i_cen),
        .o_sh_cen   (o_sh_cen),
        .o_slot     (o_slot),
        .o_zero     (o_zero),
        .i_wr_req   (i_wr_req),
        .i_wr_slot  (i_wr_slot),
        .i_wr_din   (i_wr_din),
        .o_wr_busy  (o_wr_busy),
        .o_wr_ack   (o_wr_ack),
        .o_wr_err   (o_wr_err),
        .o_sh_load  (o_sh_load),
        .o_sh_wdata (o_sh_wdata)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_pre  <= 0;
            m_slot <= 0;
        end else if (i_cen) begin
            if (m_pre == DIV - 1) begin
                m_pre  <= 0;
                m_slot <= (m_slot == STAGES - 1) ? 0 : m_slot + 1;
            end else begin
                m_pre <= m_pre + 1;
            end
        end
    end

    assign m_shcen = i_cen && (m_pre == DIV - 1);

    // Ring entry at the insertion point is replaced on the coming edge when load and shift coincide.
    always @(negedge i_clk) begin
        #3;
        if (!i_rst && o_sh_cen === 1'b1 && o_sh_load === 1'b1 && o_slot < SW'(STAGES)) begin
            ring[o_slot] = o_sh_wdata;
            load_cnt++;
        end
    end

    task automatic wait_slot(input int s);
        int n = 0;
        while (!(m_slot == s && m_pre == 0) && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL wait_slot timeout: slot %0d never reached", s);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_cen = 1'b1; i_wr_req = 1'b0; i_wr_slot = '0; i_wr_din = '0;
        for (int i = 0; i < STAGES; i++) begin ring[i] = '0; exp_ring[i] = '0; end
        exp_wdata = '0;
        repeat (3) @(negedge i_clk);
        tests++; if (o_slot !== 5'd0)     begin fails++; $display("FAIL reset_slot got %0d want 0", o_slot); end
        tests++; if (o_zero !== 1'b1)     begin fails++; $display("FAIL reset_zero got %b want 1", o_zero); end
        tests++; if (o_sh_cen !== 1'b0)   begin fails++; $display("FAIL reset_sh_cen got %b want 0", o_sh_cen); end
        tests++; if (o_wr_busy !== 1'b0)  begin fails++; $display("FAIL reset_busy got %b want 0", o_wr_busy); end
        tests++; if (o_wr_ack !== 1'b0)   begin fails++; $display("FAIL reset_ack got %b want 0", o_wr_ack); end
        tests++; if (o_wr_err !== 1'b0)   begin fails++; $display("FAIL reset_err got %b want 0", o_wr_err); end
        tests++; if (o_sh_load !== 1'b0)  begin fails++; $display("FAIL reset_load got %b want 0", o_sh_load); end
        tests++; if (o_sh_wdata !== 8'h00) begin fails++; $display("FAIL reset_wdata got %h want 00", o_sh_wdata); end
    endtask

    task automatic test_counter();
        int   rise_k = -1;
        logic prev_zero = 1'b1;
        logic e_cen;
        logic [SW-1:0] e_slot;
        i_rst = 1'b0;
        for (int k = 0; k <= 2 * STAGES * DIV; k++) begin
            e_cen  = (k % DIV == DIV - 1);
            e_slot = SW'((k / DIV) % STAGES);
            tests++; if (o_sh_cen !== e_cen)  begin fails++; $display("FAIL cnt_sh_cen k=%0d got %b want %b", k, o_sh_cen, e_cen); end
            tests++; if (o_slot !== e_slot)   begin fails++; $display("FAIL cnt_slot k=%0d got %0d want %0d", k, o_slot, e_slot); end
            tests++; if (o_zero !== (e_slot == 0)) begin fails++; $display("FAIL cnt_zero k=%0d got %b want %b", k, o_zero, e_slot == 0); end
            if (o_zero === 1'b1 && prev_zero === 1'b0 && rise_k < 0) rise_k = k;
            prev_zero = o_zero;
            @(negedge i_clk);
        end
        tests++; if (rise_k != STAGES * DIV) begin fails++; $display("FAIL cnt_period got %0d want %0d", rise_k, STAGES * DIV); end
    endtask

    task automatic test_write_basic();
        logic pend, ack_due, done, e_load;
        int   bad = 0;
        int   l0  = load_cnt;
        wait_slot(5);
        i_wr_req = 1'b1; i_wr_slot = 5'd3; i_wr_din = 8'hA5;
        @(negedge i_clk);
        tests++; if (o_wr_busy !== 1'b1)   begin fails++; $display("FAIL wb_busy got %b want 1", o_wr_busy); end
        tests++; if (o_sh_wdata !== 8'hA5) begin fails++; $display("FAIL wb_wdata got %h want a5", o_sh_wdata); end
        exp_wdata = 8'hA5; exp_ring[3] = 8'hA5;
        pend = 1'b1; ack_due = 1'b0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            e_load = pend && (m_slot == 3);
            tests++; if (o_sh_load !== e_load) begin fails++; $display("FAIL wb_load slot=%0d got %b want %b", m_slot, o_sh_load, e_load); end
            tests++; if (o_wr_ack !== ack_due) begin fails++; $display("FAIL wb_ack slot=%0d got %b want %b", m_slot, o_wr_ack, ack_due); end
            if (ack_due) begin
                done = 1'b1; i_wr_req = 1'b0;
                tests++; if (o_wr_err !== 1'b0 || o_wr_busy !== 1'b0) begin fails++; $display("FAIL wb_ack_flags err=%b busy=%b want 0 0", o_wr_err, o_wr_busy); end
            end
            ack_due = pend && m_shcen && (m_slot == 3);
            if (ack_due) pend = 1'b0;
            @(negedge i_clk);
        end
        if (!done) begin tests++; fails++; $display("FAIL wb_timeout no ack got 0 want 1"); end
        tests++; if (o_wr_ack !== 1'b0) begin fails++; $display("FAIL wb_ack_pulse got %b want 0", o_wr_ack); end
        for (int i = 0; i < STAGES; i++) if (ring[i] !== exp_ring[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL wb_ring %0d entries wrong, entry3 got %h want a5", bad, ring[3]); end
        tests++; if (load_cnt - l0 != 1) begin fails++; $display("FAIL wb_loads got %0d want 1", load_cnt - l0); end
    endtask

    task automatic test_bad_slot();
        int l0 = load_cnt;
        int bad = 0;
        int seen = 0;
        i_wr_req = 1'b1; i_wr_slot = 5'd20; i_wr_din = 8'h3C;
        @(negedge i_clk);
        tests++; if (o_wr_ack !== 1'b1)  begin fails++; $display("FAIL bad_ack got %b want 1", o_wr_ack); end
        tests++; if (o_wr_err !== 1'b1)  begin fails++; $display("FAIL bad_err got %b want 1", o_wr_err); end
        tests++; if (o_wr_busy !== 1'b0) begin fails++; $display("FAIL bad_busy got %b want 0", o_wr_busy); end
        tests++; if (o_sh_wdata !== exp_wdata) begin fails++; $display("FAIL bad_wdata got %h want %h", o_sh_wdata, exp_wdata); end
        i_wr_req = 1'b0;
        @(negedge i_clk);
        tests++; if (o_wr_ack !== 1'b0 || o_wr_err !== 1'b0) begin fails++; $display("FAIL bad_ack_pulse ack=%b err=%b want 0 0", o_wr_ack, o_wr_err); end
        for (int c = 0; c < 80; c++) begin
            if (o_sh_load !== 1'b0) seen++;
            @(negedge i_clk);
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL bad_load_seen got %0d cycles want 0", seen); end
        for (int i = 0; i < STAGES; i++) if (ring[i] !== exp_ring[i]) bad++;
        tests++; if (bad != 0 || load_cnt != l0) begin fails++; $display("FAIL bad_ring diff=%0d loads=%0d want 0 0", bad, load_cnt - l0); end
    endtask

    task automatic test_last_slot();
        logic pend, ack_due, done, e_load;
        int   bad = 0;
        wait_slot(12);
        i_wr_req = 1'b1; i_wr_slot = 5'd17; i_wr_din = 8'h71;
        exp_wdata = 8'h71; exp_ring[17] = 8'h71;
        @(negedge i_clk);
        pend = 1'b1; ack_due = 1'b0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            e_load = pend && (m_slot == 17);
            tests++; if (o_sh_load !== e_load) begin fails++; $display("FAIL last_load slot=%0d got %b want %b", m_slot, o_sh_load, e_load); end
            tests++; if (o_wr_ack !== ack_due) begin fails++; $display("FAIL last_ack slot=%0d got %b want %b", m_slot, o_wr_ack, ack_due); end
            if (ack_due) begin
                done = 1'b1; i_wr_req = 1'b0;
                tests++; if (o_slot !== 5'd0 || o_zero !== 1'b1) begin fails++; $display("FAIL last_wrap slot=%0d zero=%b want 0 1", o_slot, o_zero); end
            end
            ack_due = pend && m_shcen && (m_slot == 17);
            if (ack_due) pend = 1'b0;
            @(negedge i_clk);
        end
        if (!done) begin tests++; fails++; $display("FAIL last_timeout no ack got 0 want 1"); end
        for (int i = 0; i < STAGES; i++) if (ring[i] !== exp_ring[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL last_ring %0d wrong, entry17 got %h want 71", bad, ring[17]); end
    endtask

    task automatic test_back_to_back();
        logic pend, ack_due, done, e_load;
        int   bad = 0;
        int   l0  = load_cnt;
        wait_slot(6);
        i_wr_req = 1'b1; i_wr_slot = 5'd9; i_wr_din = 8'h99;
        @(negedge i_clk);
        tests++; if (o_wr_busy !== 1'b1 || o_sh_wdata !== 8'h99) begin fails++; $display("FAIL b2b_first busy=%b wdata=%h want 1 99", o_wr_busy, o_sh_wdata); end
        i_wr_slot = 5'd4; i_wr_din = 8'h44;
        pend = 1'b1; ack_due = 1'b0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            e_load = pend && (m_slot == 9);
            tests++; if (o_sh_load !== e_load) begin fails++; $display("FAIL b2b_load9 slot=%0d got %b want %b", m_slot, o_sh_load, e_load); end
            tests++; if (o_wr_ack !== ack_due) begin fails++; $display("FAIL b2b_ack9 slot=%0d got %b want %b", m_slot, o_wr_ack, ack_due); end
            if (pend) begin
                tests++; if (o_sh_wdata !== 8'h99) begin fails++; $display("FAIL b2b_wdata_hold got %h want 99", o_sh_wdata); end
            end
            if (ack_due) done = 1'b1;
            ack_due = pend && m_shcen && (m_slot == 9);
            if (ack_due) pend = 1'b0;
            if (!done) @(negedge i_clk);
        end
        if (!done) begin tests++; fails++; $display("FAIL b2b_timeout9 no ack got 0 want 1"); end
        @(negedge i_clk);
        tests++; if (o_wr_busy !== 1'b0 || o_wr_ack !== 1'b0) begin fails++; $display("FAIL b2b_idle busy=%b ack=%b want 0 0", o_wr_busy, o_wr_ack); end
        @(negedge i_clk);
        tests++; if (o_wr_busy !== 1'b1 || o_sh_wdata !== 8'h44) begin fails++; $display("FAIL b2b_second busy=%b wdata=%h want 1 44", o_wr_busy, o_sh_wdata); end
        exp_wdata = 8'h44; exp_ring[9] = 8'h99; exp_ring[4] = 8'h44;
        pend = 1'b1; ack_due = 1'b0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            e_load = pend && (m_slot == 4);
            tests++; if (o_sh_load !== e_load) begin fails++; $display("FAIL b2b_load4 slot=%0d got %b want %b", m_slot, o_sh_load, e_load); end
            tests++; if (o_wr_ack !== ack_due) begin fails++; $display("FAIL b2b_ack4 slot=%0d got %b want %b", m_slot, o_wr_ack, ack_due); end
            if (ack_due) begin done = 1'b1; i_wr_req = 1'b0; end
            ack_due = pend && m_shcen && (m_slot == 4);
            if (ack_due) pend = 1'b0;
            @(negedge i_clk);
        end
        if (!done) begin tests++; fails++; $display("FAIL b2b_timeout4 no ack got 0 want 1"); end
        for (int i = 0; i < STAGES; i++) if (ring[i] !== exp_ring[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL b2b_ring %0d wrong, e9=%h e4=%h want 99 44", bad, ring[9], ring[4]); end
        tests++; if (load_cnt - l0 != 2) begin fails++; $display("FAIL b2b_loads got %0d want 2", load_cnt - l0); end
    endtask

    task automatic test_reset_in_wait();
        int l0 = load_cnt;
        int acks = 0;
        int bad = 0;
        wait_slot(2);
        i_wr_req = 1'b1; i_wr_slot = 5'd10; i_wr_din = 8'h5A;
        @(negedge i_clk);
        tests++; if (o_wr_busy !== 1'b1) begin fails++; $display("FAIL rw_busy got %b want 1", o_wr_busy); end
        repeat (3) @(negedge i_clk);
        #2;
        i_rst = 1'b1; i_wr_req = 1'b0;
        #1;
        tests++; if (o_wr_busy !== 1'b0 || o_sh_load !== 1'b0 || o_wr_ack !== 1'b0) begin fails++; $display("FAIL rw_clear busy=%b load=%b ack=%b want 0 0 0", o_wr_busy, o_sh_load, o_wr_ack); end
        tests++; if (o_slot !== 5'd0 || o_zero !== 1'b1) begin fails++; $display("FAIL rw_slot slot=%0d zero=%b want 0 1", o_slot, o_zero); end
        tests++; if (o_sh_wdata !== 8'h00) begin fails++; $display("FAIL rw_wdata got %h want 00", o_sh_wdata); end
        exp_wdata = 8'h00;
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (o_wr_ack !== 1'b0) acks++;
            @(negedge i_clk);
        end
        tests++; if (acks != 0) begin fails++; $display("FAIL rw_no_ack got %0d acks want 0", acks); end
        for (int i = 0; i < STAGES; i++) if (ring[i] !== exp_ring[i]) bad++;
        tests++; if (bad != 0 || load_cnt != l0) begin fails++; $display("FAIL rw_ring diff=%0d loads=%0d want 0 0", bad, load_cnt - l0); end
    endtask

    task automatic test_cen_gap();
        logic pend, ack_due, done, e_load;
        int   tgt, frozen;
        int   bad = 0;
        int   l0  = load_cnt;
        i_cen = 1'b0;
        tgt    = (m_slot + 6) % STAGES;
        frozen = m_slot;
        i_wr_req = 1'b1; i_wr_slot = SW'(tgt); i_wr_din = 8'hC3;
        exp_wdata = 8'hC3; exp_ring[tgt] = 8'hC3;
        @(negedge i_clk);
        tests++; if (o_wr_busy !== 1'b1 || o_sh_wdata !== 8'hC3) begin fails++; $display("FAIL gap_latch busy=%b wdata=%h want 1 c3", o_wr_busy, o_sh_wdata); end
        for (int g = 0; g < 50; g++) begin
            tests++; if (o_slot !== SW'(frozen) || o_sh_cen !== 1'b0) begin fails++; $display("FAIL gap_frozen g=%0d slot=%0d sh_cen=%b want %0d 0", g, o_slot, o_sh_cen, frozen); end
            tests++; if (o_wr_busy !== 1'b1 || o_wr_ack !== 1'b0) begin fails++; $display("FAIL gap_fsm g=%0d busy=%b ack=%b want 1 0", g, o_wr_busy, o_wr_ack); end
            @(negedge i_clk);
        end
        i_cen = 1'b1;
        pend = 1'b1; ack_due = 1'b0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            e_load = pend && (m_slot == tgt);
            tests++; if (o_sh_load !== e_load) begin fails++; $display("FAIL gap_load slot=%0d got %b want %b", m_slot, o_sh_load, e_load); end
            tests++; if (o_wr_ack !== ack_due) begin fails++; $display("FAIL gap_ack slot=%0d got %b want %b", m_slot, o_wr_ack, ack_due); end
            if (ack_due) begin done = 1'b1; i_wr_req = 1'b0; end
            ack_due = pend && m_shcen && (m_slot == tgt);
            if (ack_due) pend = 1'b0;
            @(negedge i_clk);
        end
        if (!done) begin tests++; fails++; $display("FAIL gap_timeout no ack got 0 want 1"); end
        for (int i = 0; i < STAGES; i++) if (ring[i] !== exp_ring[i]) bad++;
        tests++; if (bad != 0 || load_cnt - l0 != 1) begin fails++; $display("FAIL gap_ring diff=%0d loads=%0d want 0 1", bad, load_cnt - l0); end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_write_basic();
        test_bad_slot();
        test_last_slot();
        test_back_to_back();
        test_reset_in_wait();
        test_cen_gap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
